sensor_frontend: RTL

//  Conditions raw home-automation sensor signals into the clean, stable form the integ controller samples.
//  It produces SFD, SRD, SW, SFA and ST[6:0]. Binary sensors are synchronised and debounced.

---
 rtl/sensor_frontend.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/sensor_frontend.sv
// sensor_frontend: debounces door/window/fire-alarm pins and averages
// temperature samples over a sliding window for the integ controller.
//
// Ports:
//   Clk, Rst          clock (rising edge), async active-low reset
//   fd_raw, rd_raw    front/rear door pins (asynchronous)
//   w_raw, fa_raw     window / fire-alarm pins (asynchronous)
//   temp_raw[6:0]     temperature sample, qualified by temp_valid
//   temp_valid        one-cycle sample strobe
//   SFD, SRD, SW, SFA debounced binary sensors
//   ST[6:0]           windowed mean temperature
//   ST_valid          window is full, ST is trustworthy
//   sens_chg          one-cycle pulse after any output change

module sensor_frontend_deb #(
    parameter int N = 16
) (
    input  logic Clk,
    input  logic Rst,
    input  logic raw,
    output logic q
);

    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            cnt <= '0;
            q   <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == q) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                q   <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

module sensor_frontend #(
    parameter int DEB_CYCLES = 16,
    parameter int FA_DEB     = 4,
    parameter int AVG_LOG2   = 2
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       fd_raw,
    input  logic       rd_raw,
    input  logic       w_raw,
    input  logic       fa_raw,
    input  logic [6:0] temp_raw,
    input  logic       temp_valid,
    output logic       SFD,
    output logic       SRD,
    output logic       SW,
    output logic       SFA,
    output logic [6:0] ST,
    output logic       ST_valid,
    output logic       sens_chg
);

    localparam int W    = 1 << AVG_LOG2;
    localparam int PW   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int SUMW = 7 + AVG_LOG2;
    localparam int FW   = AVG_LOG2 + 1;

    // Binary channels
    sensor_frontend_deb #(.N(DEB_CYCLES)) u_fd (
        .Clk (Clk),
        .Rst (Rst),
        .raw (fd_raw),
        .q   (SFD)
    );

    sensor_frontend_deb #(.N(DEB_CYCLES)) u_rd (
        .Clk (Clk),
        .Rst (Rst),
        .raw (rd_raw),
        .q   (SRD)
    );

    sensor_frontend_deb #(.N(DEB_CYCLES)) u_w (
        .Clk (Clk),
        .Rst (Rst),
        .raw (w_raw),
        .q   (SW)
    );

    sensor_frontend_deb #(.N(FA_DEB)) u_fa (
        .Clk (Clk),
        .Rst (Rst),
        .raw (fa_raw),
        .q   (SFA)
    );

    // Temperature window
    logic [6:0]      win [W];
    logic [PW-1:0]   wp;
    logic [PW-1:0]   wp_nxt;
    logic [SUMW-1:0] sum;
    logic [FW-1:0]   fill;
    logic            full;
    logic [6:0]      oldest;

    assign full = (fill == FW'(W));

    // Until the window is full the slot being overwritten holds no
    // sample yet, so it must not be subtracted from the sum.
    assign oldest = full ? win[wp] : 7'd0;

    assign wp_nxt = (wp == PW'(W - 1)) ? '0 : wp + 1'b1;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < W; i++) begin
                win[i] <= '0;
            end
            wp   <= '0;
            sum  <= '0;
            fill <= '0;
        end else if (temp_valid) begin
            win[wp] <= temp_raw;
            wp      <= wp_nxt;
            sum     <= sum + SUMW'(temp_raw) - SUMW'(oldest);
            if (!full) begin
                fill <= fill + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            ST       <= '0;
            ST_valid <= 1'b0;
        end else begin
            ST       <= full ? 7'(sum >> AVG_LOG2) : 7'd0;
            ST_valid <= full;
        end
    end

    // Change detect on the output vector
    logic [10:0] cur;
    logic [10:0] prev;

    assign cur = {SFD, SRD, SW, SFA, ST};

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            prev     <= '0;
            sens_chg <= 1'b0;
        end else begin
            prev     <= cur;
            sens_chg <= (cur != prev);
        end
    end

endmodule
